// File: rtl/hsv_mask_pipe_pkg.sv
// Shared constants and types for the HSV colour-mask pipeline.
package hsv_pkg;
  localparam int HUE_W = 14;

  localparam logic [1:0] CFG_LO_Q    = 2'd0;
  localparam logic [1:0] CFG_HI_Q    = 2'd1;
  localparam logic [1:0] CFG_V_SHIFT = 2'd2;

  localparam logic [7:0] DEF_LO_Q    = 8'd3;
  localparam logic [7:0] DEF_HI_Q    = 8'd9;
  localparam logic [7:0] DEF_V_SHIFT = 8'd2;

  typedef enum logic [1:0] {CH_R, CH_G, CH_B} chan_t;

  typedef struct packed {
    logic [7:0] lo_q;
    logic [7:0] hi_q;
    logic [7:0] v_shift;
  } cfg_t;
endpackage

// File: rtl/hsv_mask_pipe_if.sv
// Pixel stream in/out, config port and frame-count result of the mask pipeline.
interface hsv_mask_pipe_if #(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 13,
  parameter int CNT_W   = 19
);
  logic               i_valid, i_sof;
  logic [DATA_W-1:0]  i_R, i_G, i_B;
  logic [COORD_W-1:0] i_row, i_col;
  logic               i_cfg_we;
  logic [1:0]         i_cfg_addr;
  logic [7:0]         i_cfg_data;
  logic               o_valid;
  logic [DATA_W-1:0]  o_R, o_G, o_B;
  logic [COORD_W-1:0] o_row, o_col;
  logic               o_color_raw, o_color;
  logic [CNT_W-1:0]   o_count;
  logic               o_count_valid;

  modport master (
    output i_valid, i_sof, i_R, i_G, i_B, i_row, i_col, i_cfg_we, i_cfg_addr, i_cfg_data,
    input  o_valid, o_R, o_G, o_B, o_row, o_col, o_color_raw, o_color, o_count, o_count_valid
  );
  modport slave (
    input  i_valid, i_sof, i_R, i_G, i_B, i_row, i_col, i_cfg_we, i_cfg_addr, i_cfg_data,
    output o_valid, o_R, o_G, o_B, o_row, o_col, o_color_raw, o_color, o_count, o_count_valid
  );
endinterface

// File: rtl/hsv_mask_pipe_core.sv
// Two registered stages: max/min/channel select, then saturation, hue numerator and bounds.
module hsv_core
  import hsv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  input  cfg_t               cfg,
  input  logic               valid,
  input  logic               sof,
  input  logic [DATA_W-1:0]  r, g, b,
  input  logic [COORD_W-1:0] row, col,
  output logic               s2_valid, s2_sof,
  output logic [DATA_W-1:0]  s2_r, s2_g, s2_b,
  output logic [COORD_W-1:0] s2_row, s2_col,
  output logic [DATA_W-1:0]  s2_sat, s2_vth,
  output logic [HUE_W-1:0]   s2_hue,
  output logic [HUE_W-1:0]   s2_lo, s2_hi
);
  localparam int PW = DATA_W + 8;

  logic               s1_valid, s1_sof;
  logic [DATA_W-1:0]  s1_r, s1_g, s1_b, s1_max, s1_min;
  logic [COORD_W-1:0] s1_row, s1_col;
  chan_t              s1_sel;

  chan_t             sel;
  logic [DATA_W-1:0] mx, mn;
  always_comb begin
    if (r >= g && r >= b) begin sel = CH_R; mx = r; end
    else if (g >= b)      begin sel = CH_G; mx = g; end
    else                  begin sel = CH_B; mx = b; end
    mn = r;
    if (g < mn) mn = g;
    if (b < mn) mn = b;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0; s1_sof <= 1'b0; s1_sel <= CH_R;
      s1_r <= '0; s1_g <= '0; s1_b <= '0; s1_max <= '0; s1_min <= '0;
      s1_row <= '0; s1_col <= '0;
    end else begin
      s1_valid <= valid; s1_sof <= sof; s1_sel <= sel;
      s1_r <= r; s1_g <= g; s1_b <= b; s1_max <= mx; s1_min <= mn;
      s1_row <= row; s1_col <= col;
    end
  end

  // Hue is formed modulo 2^HUE_W so the result is the two's complement numerator.
  logic [DATA_W-1:0] sat;
  logic [HUE_W-1:0]  hue, sz, rz, gz, bz;
  logic [PW-1:0]     lo_p, hi_p;
  always_comb begin
    sat = s1_max - s1_min;
    sz = HUE_W'(sat);
    rz = HUE_W'(s1_r);
    gz = HUE_W'(s1_g);
    bz = HUE_W'(s1_b);
    case (s1_sel)
      CH_R:    hue = gz - bz;
      CH_G:    hue = (sz << 1) + bz - rz;
      default: hue = (sz << 2) + rz - gz;
    endcase
    lo_p = PW'(sat) * PW'(cfg.lo_q);
    hi_p = PW'(sat) * PW'(cfg.hi_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0; s2_sof <= 1'b0;
      s2_r <= '0; s2_g <= '0; s2_b <= '0; s2_row <= '0; s2_col <= '0;
      s2_sat <= '0; s2_vth <= '0; s2_hue <= '0; s2_lo <= '0; s2_hi <= '0;
    end else begin
      s2_valid <= s1_valid; s2_sof <= s1_sof;
      s2_r <= s1_r; s2_g <= s1_g; s2_b <= s1_b; s2_row <= s1_row; s2_col <= s1_col;
      s2_sat <= sat;
      s2_vth <= s1_max >> cfg.v_shift;
      s2_hue <= hue;
      s2_lo  <= HUE_W'(lo_p >> 2);
      s2_hi  <= HUE_W'(hi_p >> 2);
    end
  end
endmodule

// File: rtl/hsv_mask_pipe.sv
// HSV colour mask with frame-aligned config, same-row majority filter and per-frame pixel count.
module hsv_mask_pipe
  import hsv_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int COORD_W = 13,
  parameter int ROW_MAX = 477,
  parameter int COL_MAX = 617,
  parameter int TAPS    = 5,
  parameter int CNT_W   = 19
) (
  input logic           iCLK,
  input logic           iRST_N,
  hsv_mask_pipe_if.slave bus
);
  localparam int H      = (TAPS - 1) / 2;
  localparam int VOTE_W = $clog2(TAPS + 1);

  typedef struct packed {
    logic               valid;
    logic               sof;
    logic               raw;
    logic [DATA_W-1:0]  r, g, b;
    logic [COORD_W-1:0] row, col;
  } tap_t;

  // Shadow takes writes at once; active only reloads as a new frame enters the pipe.
  cfg_t shadow, active;
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      shadow <= '{lo_q: DEF_LO_Q, hi_q: DEF_HI_Q, v_shift: DEF_V_SHIFT};
      active <= '{lo_q: DEF_LO_Q, hi_q: DEF_HI_Q, v_shift: DEF_V_SHIFT};
    end else begin
      if (bus.i_valid && bus.i_sof) active <= shadow;
      if (bus.i_cfg_we) begin
        case (bus.i_cfg_addr)
          CFG_LO_Q:    shadow.lo_q    <= bus.i_cfg_data;
          CFG_HI_Q:    shadow.hi_q    <= bus.i_cfg_data;
          CFG_V_SHIFT: shadow.v_shift <= bus.i_cfg_data;
          default: ;
        endcase
      end
    end
  end

  logic               s2_valid, s2_sof;
  logic [DATA_W-1:0]  s2_r, s2_g, s2_b, s2_sat, s2_vth;
  logic [COORD_W-1:0] s2_row, s2_col;
  logic [HUE_W-1:0]   s2_hue, s2_lo, s2_hi;

  hsv_core #(.DATA_W(DATA_W), .COORD_W(COORD_W)) u_core (
    .clk(iCLK), .rst_n(iRST_N), .cfg(active),
    .valid(bus.i_valid), .sof(bus.i_sof),
    .r(bus.i_R), .g(bus.i_G), .b(bus.i_B), .row(bus.i_row), .col(bus.i_col),
    .s2_valid(s2_valid), .s2_sof(s2_sof),
    .s2_r(s2_r), .s2_g(s2_g), .s2_b(s2_b), .s2_row(s2_row), .s2_col(s2_col),
    .s2_sat(s2_sat), .s2_vth(s2_vth), .s2_hue(s2_hue), .s2_lo(s2_lo), .s2_hi(s2_hi)
  );

  logic in_win, hue_fail;
  tap_t new_tap;
  always_comb begin
    in_win   = (s2_row <= COORD_W'(ROW_MAX)) && (s2_col <= COORD_W'(COL_MAX));
    // A negative numerator never lies inside the (non-negative) bounds.
    hue_fail = s2_hue[HUE_W-1] || (s2_hue < s2_lo) || (s2_hue > s2_hi);
    new_tap.valid = s2_valid;
    new_tap.sof   = s2_sof;
    new_tap.raw   = in_win && s2_valid && !hue_fail && !(s2_sat < s2_vth);
    new_tap.r     = in_win ? s2_r : '0;
    new_tap.g     = in_win ? s2_g : '0;
    new_tap.b     = in_win ? s2_b : '0;
    new_tap.row   = s2_row;
    new_tap.col   = s2_col;
  end

  tap_t [TAPS-1:0] taps;
  always_ff @(posedge iCLK) begin
    if (!iRST_N) taps <= '0;
    else         taps <= {taps[TAPS-2:0], new_tap};
  end

  // Only taps on the centre's row vote, so line edges never borrow from neighbours.
  logic [VOTE_W-1:0] votes;
  logic              color;
  always_comb begin
    votes = '0;
    for (int i = 0; i < TAPS; i++)
      if (taps[i].raw && taps[i].row == taps[H].row) votes = votes + VOTE_W'(1);
    color = taps[H].valid && (votes >= VOTE_W'(H + 1));
  end

  logic [CNT_W-1:0] acc, count;
  logic             count_valid;
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      acc <= '0; count <= '0; count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (taps[H].valid && taps[H].sof) begin
        count       <= acc;
        count_valid <= 1'b1;
        acc         <= CNT_W'(color);
      end else if (color && acc != '1) begin
        acc <= acc + CNT_W'(1);
      end
    end
  end

  assign bus.o_valid       = taps[H].valid;
  assign bus.o_R           = taps[H].r;
  assign bus.o_G           = taps[H].g;
  assign bus.o_B           = taps[H].b;
  assign bus.o_row         = taps[H].row;
  assign bus.o_col         = taps[H].col;
  assign bus.o_color_raw   = taps[H].raw;
  assign bus.o_color       = color;
  assign bus.o_count       = count;
  assign bus.o_count_valid = count_valid;
endmodule

// File: tb/tb_hsv_mask_pipe.sv
// Directed and randomized pixel streams compared cycle by cycle against a frame-level model.
module tb_hsv_mask_pipe;
  localparam int DATA_W = 8, COORD_W = 13, ROW_MAX = 477, COL_MAX = 617, TAPS = 5, CNT_W = 4;
  localparam int H = (TAPS - 1) / 2, L = 3 + H, CMAX = (1 << CNT_W) - 1;

  logic iCLK = 1'b0, iRST_N = 1'b0;
  always #5 iCLK = ~iCLK;

  hsv_mask_pipe_if #(.DATA_W(DATA_W), .COORD_W(COORD_W), .CNT_W(CNT_W)) bus ();
  hsv_mask_pipe #(.DATA_W(DATA_W), .COORD_W(COORD_W), .ROW_MAX(ROW_MAX), .COL_MAX(COL_MAX),
                  .TAPS(TAPS), .CNT_W(CNT_W)) dut (.iCLK(iCLK), .iRST_N(iRST_N), .bus(bus));

  typedef struct { bit v; bit sof; int r, g, b, row, col; } px_t;

  px_t hist[$];
  bit  exp_raw[$];
  int  sh_lo, sh_hi, sh_vs, ac_lo, ac_hi, ac_vs;
  int  m_acc, m_cnt;
  bit  m_cv;
  int  errors = 0, checks = 0;
  bit  cap_raw[int], cap_color[int];
  int  cap_rgb[int];
  int  last_pub, pub_n, last_idx;

  function automatic px_t mk(bit v, bit sof, int r, int g, int b, int row, int col);
    px_t p;
    p.v = v; p.sof = sof; p.r = r; p.g = g; p.b = b; p.row = row; p.col = col;
    return p;
  endfunction
  function automatic px_t maskp(int row, int col); return mk(1, 0, 200, 180, 20, row, col); endfunction
  function automatic px_t grayp(int row, int col); return mk(1, 0, 100, 100, 100, row, col); endfunction
  function automatic px_t idle(); return mk(0, 0, 0, 0, 0, 0, 0); endfunction

  // Classification straight from the colour rules, in plain integer arithmetic.
  function automatic bit ref_raw(px_t p, int lo_q, int hi_q, int vs);
    int mx, mn, s, h;
    if (!p.v || p.row > ROW_MAX || p.col > COL_MAX) return 0;
    mx = p.r; if (p.g > mx) mx = p.g; if (p.b > mx) mx = p.b;
    mn = p.r; if (p.g < mn) mn = p.g; if (p.b < mn) mn = p.b;
    s = mx - mn;
    if (p.r >= p.g && p.r >= p.b) h = p.g - p.b;
    else if (p.g >= p.b)          h = 2 * s + p.b - p.r;
    else                          h = 4 * s + p.r - p.g;
    return (h >= (s * lo_q) / 4) && (h <= (s * hi_q) / 4) && (s >= ((vs >= 31) ? 0 : (mx >> vs)));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle_check();
    int n, k, votes, e_rgb, e_coord;
    bit ev, eraw, ecolor, esof;
    n = hist.size() - 1;
    k = n - (L - 1);
    ev = 0; eraw = 0; ecolor = 0; esof = 0; e_rgb = 0; e_coord = 0;
    if (k >= 0) begin
      ev = hist[k].v; esof = hist[k].sof; eraw = exp_raw[k];
      if (hist[k].row <= ROW_MAX && hist[k].col <= COL_MAX)
        e_rgb = (hist[k].r << 16) | (hist[k].g << 8) | hist[k].b;
      e_coord = (hist[k].row << COORD_W) | hist[k].col;
      votes = 0;
      for (int j = k - H; j <= k + H; j++)
        if (j >= 0 && j < hist.size() && exp_raw[j] && hist[j].row == hist[k].row) votes++;
      ecolor = ev && (votes >= H + 1);
    end
    check("count", 64'(bus.o_count), 64'(m_cnt));
    check("count_valid", 64'(bus.o_count_valid), 64'(m_cv));
    check("valid", 64'(bus.o_valid), 64'(ev));
    check("rgb", 64'({bus.o_R, bus.o_G, bus.o_B}), 64'(e_rgb));
    check("coord", 64'({bus.o_row, bus.o_col}), 64'(e_coord));
    check("color_raw", 64'(bus.o_color_raw), 64'(eraw));
    check("color", 64'(bus.o_color), 64'(ecolor));
    if (k >= 0) begin
      cap_raw[k] = bus.o_color_raw; cap_color[k] = bus.o_color;
      cap_rgb[k] = int'({bus.o_R, bus.o_G, bus.o_B});
    end
    if (bus.o_count_valid) begin last_pub = int'(bus.o_count); pub_n++; end
    if (k >= 0 && ev && esof) begin
      m_cv = 1; m_cnt = m_acc; m_acc = ecolor;
    end else begin
      m_cv = 0;
      if (ecolor && m_acc < CMAX) m_acc++;
    end
  endtask

  task automatic step_w(input px_t p, input bit we, input int addr, input int data);
    @(negedge iCLK);
    iRST_N = 1'b1;
    bus.i_valid = p.v; bus.i_sof = p.sof;
    bus.i_R = DATA_W'(p.r); bus.i_G = DATA_W'(p.g); bus.i_B = DATA_W'(p.b);
    bus.i_row = COORD_W'(p.row); bus.i_col = COORD_W'(p.col);
    bus.i_cfg_we = we; bus.i_cfg_addr = 2'(addr); bus.i_cfg_data = 8'(data);
    if (p.v && p.sof) begin ac_lo = sh_lo; ac_hi = sh_hi; ac_vs = sh_vs; end
    hist.push_back(p);
    exp_raw.push_back(ref_raw(p, ac_lo, ac_hi, ac_vs));
    last_idx = hist.size() - 1;
    if (we) case (addr)
      0: sh_lo = data;
      1: sh_hi = data;
      2: sh_vs = data;
      default: ;
    endcase
    @(posedge iCLK); #1;
    cycle_check();
  endtask

  task automatic step(input px_t p); step_w(p, 0, 0, 0); endtask
  task automatic flush(input int n); for (int i = 0; i < n; i++) step(idle()); endtask

  task automatic do_reset();
    @(negedge iCLK);
    iRST_N = 1'b0;
    bus.i_valid = 0; bus.i_sof = 0; bus.i_R = 0; bus.i_G = 0; bus.i_B = 0;
    bus.i_row = 0; bus.i_col = 0; bus.i_cfg_we = 0; bus.i_cfg_addr = 0; bus.i_cfg_data = 0;
    @(posedge iCLK); @(posedge iCLK); #1;
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_rgb", 64'({bus.o_R, bus.o_G, bus.o_B}), 64'd0);
    check("rst_coord", 64'({bus.o_row, bus.o_col}), 64'd0);
    check("rst_mask", 64'({bus.o_color_raw, bus.o_color}), 64'd0);
    check("rst_count", 64'({bus.o_count, bus.o_count_valid}), 64'd0);
    hist.delete(); exp_raw.delete();
    cap_raw.delete(); cap_color.delete(); cap_rgb.delete();
    sh_lo = 3; sh_hi = 9; sh_vs = 2; ac_lo = 3; ac_hi = 9; ac_vs = 2;
    m_acc = 0; m_cnt = 0; m_cv = 0; pub_n = 0; last_pub = -1;
  endtask

  initial begin
    int ia, ig, ir, base, i617, i618, i31, im, inx;
    bit pat [0:10];
    int row, col, mode, r, g, b;
    bit v;
    px_t p;

    do_reset();

    // Basic classification with default thresholds.
    step(mk(1, 1, 100, 100, 100, 0, 0));
    step(maskp(10, 10));            ia = last_idx;
    step(grayp(10, 11));            ig = last_idx;
    step(mk(1, 0, 255, 0, 0, 10, 12)); ir = last_idx;
    flush(L);
    check("dir_hue_in_range", 64'(cap_raw[ia]), 64'd1);
    check("dir_gray", 64'(cap_raw[ig]), 64'd0);
    check("dir_pure_red", 64'(cap_raw[ir]), 64'd0);

    // Lone pixel is filtered out; a run of three survives.
    pat = '{0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 0};
    for (int i = 0; i <= 10; i++) begin
      step(pat[i] ? maskp(20, 100 + i) : grayp(20, 100 + i));
      if (i == 0) base = last_idx;
    end
    flush(L);
    check("dir_lone_raw", 64'(cap_raw[base + 2]), 64'd1);
    check("dir_lone_color", 64'(cap_color[base + 2]), 64'd0);
    check("dir_run_color", 64'(cap_color[base + 7]), 64'd1);

    // Row edge: three at end of row 30, out-of-window col 618, three at start of row 31.
    for (int c = 612; c <= 617; c++) begin
      step(c >= 615 ? maskp(30, c) : grayp(30, c));
      if (c == 617) i617 = last_idx;
    end
    step(maskp(30, 618)); i618 = last_idx;
    for (int c = 0; c <= 5; c++) begin
      step(c <= 2 ? maskp(31, c) : grayp(31, c));
      if (c == 0) i31 = last_idx;
    end
    flush(L);
    check("edge_617_color", 64'(cap_color[i617]), 64'd1);
    check("edge_618_rgb", 64'(cap_rgb[i618]), 64'd0);
    check("edge_618_raw", 64'(cap_raw[i618]), 64'd0);
    check("edge_next_row_color", 64'(cap_color[i31]), 64'd1);

    // Two plus two across a row boundary must not combine into a majority.
    for (int c = 614; c <= 617; c++) begin
      step(c >= 616 ? maskp(40, c) : grayp(40, c));
      if (c == 617) i617 = last_idx;
    end
    for (int c = 0; c <= 3; c++) begin
      step(c <= 1 ? maskp(41, c) : grayp(41, c));
      if (c == 0) i31 = last_idx;
    end
    flush(L);
    check("split_617_raw", 64'(cap_raw[i617]), 64'd1);
    check("split_617_color", 64'(cap_color[i617]), 64'd0);
    check("split_next_color", 64'(cap_color[i31]), 64'd0);

    // Mid-frame HI_Q write waits for the next frame; a write on the sof cycle waits one more.
    step_w(grayp(50, 0), 1, 1, 3);
    step(maskp(50, 1)); im = last_idx;
    flush(L);
    step(mk(1, 1, 100, 100, 100, 0, 0));
    step(maskp(10, 10)); inx = last_idx;
    flush(L);
    check("cfg_midframe_hold", 64'(cap_raw[im]), 64'd1);
    check("cfg_next_frame", 64'(cap_raw[inx]), 64'd0);
    step_w(mk(1, 1, 100, 100, 100, 0, 0), 1, 1, 9);
    step_w(maskp(10, 10), 1, 3, 0); im = last_idx;
    flush(L);
    step(mk(1, 1, 100, 100, 100, 0, 0));
    step(maskp(10, 10)); inx = last_idx;
    flush(L);
    check("cfg_sof_write_deferred", 64'(cap_raw[im]), 64'd0);
    check("cfg_sof_write_applied", 64'(cap_raw[inx]), 64'd1);

    // Counter: first sof publishes 0; 20 mask pixels saturate a 4-bit count.
    do_reset();
    step(mk(1, 1, 100, 100, 100, 0, 0));
    flush(L + 1);
    check("cnt_first_pub_n", 64'(pub_n), 64'd1);
    check("cnt_first_value", 64'(last_pub), 64'd0);
    for (int c = 0; c < 20; c++) step(maskp(5, c));
    step(grayp(5, 20));
    step(mk(1, 1, 100, 100, 100, 0, 0));
    flush(L + 1);
    check("cnt_sat_pub_n", 64'(pub_n), 64'd2);
    check("cnt_sat_value", 64'(last_pub), 64'(CMAX));

    // Reset with pixels in flight.
    step(mk(1, 1, 200, 180, 20, 0, 0));
    step(maskp(0, 1));
    step(maskp(0, 2));
    do_reset();
    flush(L);

    // Randomized frames with gaps, row changes, out-of-window pixels and config writes.
    for (int f = 0; f < 4; f++) begin
      row = 0; col = 0; mode = 1;
      for (int i = 0; i < 120; i++) begin
        if ($urandom_range(0, 5) == 0) mode = int'($urandom_range(0, 2));
        v = (i == 0) || ($urandom_range(0, 6) != 0);
        case (mode)
          0: begin r = int'($urandom_range(0, 255)); g = int'($urandom_range(0, 255)); b = int'($urandom_range(0, 255)); end
          1: begin r = int'($urandom_range(170, 255)); g = int'($urandom_range(120, 170)); b = int'($urandom_range(0, 50)); end
          default: begin r = int'($urandom_range(0, 60)); g = int'($urandom_range(150, 255)); b = int'($urandom_range(80, 150)); end
        endcase
        p = v ? mk(1, i == 0, r, g, b, row, col) : idle();
        if ($urandom_range(0, 24) == 0) step_w(p, 1, int'($urandom_range(0, 3)), int'($urandom_range(0, 10)));
        else step(p);
        if (v) begin
          col++;
          if (col > 620 || $urandom_range(0, 19) == 0) begin
            row = ($urandom_range(0, 9) == 0) ? 478 + int'($urandom_range(0, 3)) : row + 1;
            col = ($urandom_range(0, 2) == 0) ? 610 : 0;
          end
        end
      end
    end
    step(mk(1, 1, 100, 100, 100, 0, 0));
    flush(L + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
